instr_line_buffer: RTL and testbench
====================================

Name: instr_line_buffer

Overview:
Sits between memory_fetch (512-bit line source) and the decoder. It holds one fetched 64-byte line and serves sequential 32-bit instructions to the decoder through a valid/ready handshake. It issues a new line request on a line crossing or on a redirect miss, and discards stale line responses after a redirect.

Parameters:
ADDR_WIDTH, 64, PC and address width
LINE_BITS, 512, fetched line width (64 bytes, 16 instructions)
INSTR_WIDTH, 32, instruction width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  load new PC this cycle (used for entry after reset and for branches)
redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0)
mem_req_valid  output  1  line request to memory_fetch
mem_req_addr  output  ADDR_WIDTH  line-aligned request address ({pc[63:6],6'b0})
mem_resp_valid  input  1  one-cycle pulse: line data valid
mem_resp_data  input  LINE_BITS  returned line; byte 0 in bits [7:0]
instr_valid  output  1  instr/instr_pc valid
instr  output  INSTR_WIDTH  instruction word at instr_pc
instr_pc  output  ADDR_WIDTH  PC of instr
instr_ready  input  1  decoder accepts instr this cycle

Behaviour:
- Reset (reset low, async): state=IDLE, pc=0, line_tag=0, line_valid=0, discard=0. All outputs 0.
- State IDLE: no valid PC. On redirect_valid: pc<=redirect_pc&~3, go to REQ.
- State REQ: mem_req_valid=1, mem_req_addr={pc[63:6],6'b0}, instr_valid=0.
  - mem_req_valid stays high until mem_resp_valid, and is low in the cycle after the response.
  - On mem_resp_valid with discard=0: latch data; line_tag<=pc[63:6]; line_valid<=1; go to SERVE.
  - On mem_resp_valid with discard=1: drop data; discard<=0; stay in REQ and reissue the request for the current pc next cycle.
  - redirect_valid in REQ: pc<=new pc; discard<=1, unless mem_resp_valid arrives the same cycle, in which case that response is dropped and discard stays 0.
- State SERVE: instr_valid=1; instr=line word pc[5:2] (bits [32*k+31:32*k]); instr_pc=pc.
  - Handshake (instr_valid & instr_ready & !redirect_valid): pc<=pc+4. If pc[5:2]==15, go to REQ; otherwise stay in SERVE (next instruction on the next cycle, throughput 1/cycle).
  - redirect_valid: pc<=new pc. If new pc[63:6]==line_tag and line_valid, stay in SERVE (hit, instr_valid next cycle). Otherwise go to REQ.
- Redirect has priority over the handshake in the same cycle. An instruction offered in that cycle counts as discarded and pc does not advance.
- pc+4 wraps modulo 2^ADDR_WIDTH. From 0xFFFF_FFFF_FFFF_FFFC it goes to 0, which is a line crossing.
- Latency:
  - Redirect miss at cycle N: mem_req_valid at N+1.
  - Response at cycle M: instr_valid at M+1.
  - Redirect hit at N: instr_valid with the new pc at N+1.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
- Reset asserted mid-request: return to IDLE immediately. Any response arriving after reset deasserts, before a redirect, is ignored in IDLE.

Decomposition:
- Package fetch_pkg holds:
  - LINE_BYTES=64, WORDS_PER_LINE=16, OFFSET_BITS=6
  - typedef enum {IDLE, REQ, SERVE} fetch_state_t
  - typedef logic [63:0] addr_t
- Sub-module line_word_select: combinational 512-to-32 mux indexed by pc[5:2].

Test Plan:
- Reset then redirect_pc=0x1000_0008 → mem_req_valid=1, mem_req_addr=0x1000_0000 next cycle. Respond with word k=k+0x100 → instr=0x102, instr_pc=0x1000_0008 one cycle after the response.
- instr_ready held 1 from 0x1000_0038 → instrs 0x10E, 0x10F, then instr_valid=0 and mem_req_addr=0x1000_0040 on the next cycle.
- instr_ready=0 for 5 cycles in SERVE → instr and instr_pc unchanged, pc does not advance.
- Redirect to 0x1000_0020 while serving line 0x1000_0000 → hit: instr=0x108 next cycle, no mem_req_valid.
- Redirect to 0x2000_0000 while in REQ for 0x1000_0040 → the first response is dropped (instr_valid stays 0), mem_req_addr=0x2000_0000 is reissued, and the second response is served.
- Redirect and instr_ready=1 in the same cycle → redirect wins, instr_pc becomes the redirect target, and the old pc+4 is never presented.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction line buffer.
// Contents:
//   LINE_BYTES, WORDS_PER_LINE, OFFSET_BITS - geometry of one fetched line
//   fetch_state_t                           - buffer control states
//   addr_t                                  - 64-bit fetch address
package fetch_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_BITS    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } fetch_state_t;

  typedef logic [63:0] addr_t;

endpackage

// File: rtl/instr_line_buffer_if.sv
// Bus bundle for the instruction line buffer.
// Groups three channels:
//   redirect : redirect_valid / redirect_pc        (core -> buffer)
//   memory   : mem_req_valid / mem_req_addr         (buffer -> memory_fetch)
//              mem_resp_valid / mem_resp_data       (memory_fetch -> buffer)
//   decode   : instr_valid / instr / instr_pc       (buffer -> decoder)
//              instr_ready                          (decoder -> buffer)
// Modports:
//   master : the line buffer itself
//   slave  : the surrounding environment (core, memory, decoder)
interface instr_line_buffer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_BITS   = LINE_BYTES * 8,
  parameter int INSTR_WIDTH = 32
);

  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   mem_req_valid;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic                   mem_resp_valid;
  logic [LINE_BITS-1:0]   mem_resp_data;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_resp_valid, mem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_resp_valid, mem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/line_word_select.sv
// Combinational word extractor: picks instruction word idx out of a
// fetched line. Word k occupies bits [INSTR_WIDTH*k +: INSTR_WIDTH],
// so byte 0 of the line lands in the low byte of word 0.
// Ports:
//   line : full fetched line
//   idx  : word index within the line (pc word offset)
//   word : selected instruction word
module line_word_select
  import fetch_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BYTES * 8,
  parameter int INSTR_WIDTH = 32,
  localparam int IDX_W      = $clog2(LINE_BITS / INSTR_WIDTH)
) (
  input  logic [LINE_BITS-1:0]   line,
  input  logic [IDX_W-1:0]       idx,
  output logic [INSTR_WIDTH-1:0] word
);

  assign word = line[idx * INSTR_WIDTH +: INSTR_WIDTH];

endmodule

// File: rtl/instr_line_buffer.sv
// Instruction line buffer between memory_fetch and the decoder.
// Holds one 64-byte line and streams sequential 32-bit instructions to
// the decoder at up to one per cycle. A new line is requested when the
// stream crosses a line boundary or a redirect misses the held line.
// Responses to a request that was overtaken by a redirect are dropped.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : redirect / memory / decode channels (master side)
module instr_line_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_BITS   = LINE_BYTES * 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_line_buffer_if.master bus
);

  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [TAG_W-1:0]       line_tag_q, line_tag_d;
  logic                   line_valid_q, line_valid_d;
  logic                   discard_q, discard_d;
  logic                   load_line;
  logic [LINE_BITS-1:0]   line_q;
  logic [INSTR_WIDTH-1:0] word;
  logic [ADDR_WIDTH-1:0]  redir_pc;
  logic [IDX_W-1:0]       word_idx;
  logic                   redir_hit;

  // Instructions are word aligned; the low two address bits are dropped.
  assign redir_pc  = bus.redirect_pc & ~ADDR_WIDTH'(3);
  assign word_idx  = pc_q[OFFSET_BITS-1:2];
  assign redir_hit = line_valid_q && (redir_pc[ADDR_WIDTH-1:OFFSET_BITS] == line_tag_q);

  line_word_select #(
    .LINE_BITS  (LINE_BITS),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_word_select (
    .line(line_q),
    .idx (word_idx),
    .word(word)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    discard_d    = discard_q;
    load_line    = 1'b0;

    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.instr_valid   = 1'b0;
    bus.instr         = '0;
    bus.instr_pc      = '0;

    unique case (state_q)
      IDLE: begin
        // Stray responses are ignored here; only a redirect starts fetching.
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end
      end

      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {pc_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (bus.redirect_valid) begin
          // A response arriving alongside the redirect is consumed right
          // here, so nothing stale is left in flight to skip later.
          pc_d      = redir_pc;
          discard_d = !bus.mem_resp_valid;
        end else if (bus.mem_resp_valid) begin
          if (discard_q) begin
            // Stale line for a PC we no longer want; ask again for pc_q.
            discard_d = 1'b0;
          end else begin
            load_line    = 1'b1;
            line_tag_d   = pc_q[ADDR_WIDTH-1:OFFSET_BITS];
            line_valid_d = 1'b1;
            state_d      = SERVE;
          end
        end
      end

      SERVE: begin
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        bus.instr_pc    = pc_q;
        // Redirect overrides any handshake in the same cycle.
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = redir_hit ? SERVE : REQ;
        end else if (bus.instr_ready) begin
          pc_d = pc_q + ADDR_WIDTH'(4);
          if (word_idx == IDX_W'(WORDS_PER_LINE - 1)) begin
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      discard_q    <= discard_d;
    end
  end

  // Line storage is never read outside SERVE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_line) begin
      line_q <= bus.mem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed scoreboard bench for instr_line_buffer.
// Stimulus pushes expected decoder handshakes and expected request state
// at each memory response; a negedge monitor pops and compares them.
module tb_instr_line_buffer;
  import fetch_pkg::*;

  localparam int AW = 64;
  localparam int LB = 512;
  localparam int IW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_line_buffer_if #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .INSTR_WIDTH(IW)) bus ();

  instr_line_buffer #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .INSTR_WIDTH(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } instr_exp_t;

  typedef struct {
    logic        req_valid;
    logic [63:0] addr;
  } req_exp_t;

  instr_exp_t exp_instr_q[$];
  req_exp_t   exp_req_q[$];
  instr_exp_t ei;
  req_exp_t   er;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  task automatic respond(input logic [31:0] base, input logic exp_v, input logic [63:0] exp_addr);
    req_exp_t r;
    r.req_valid = exp_v;
    r.addr      = exp_addr;
    exp_req_q.push_back(r);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = make_line(base);
  endtask

  task automatic expect_instr(input logic [63:0] pc, input logic [31:0] ins);
    instr_exp_t x;
    x.pc    = pc;
    x.instr = ins;
    exp_instr_q.push_back(x);
  endtask

  // Monitor: every accepted instruction and every memory response is scored.
  always @(negedge clk) begin
    if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (exp_instr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc 0x%0h instr 0x%0h, expected no handshake",
                 bus.instr_pc, bus.instr);
      end else begin
        ei = exp_instr_q.pop_front();
        check("sb_instr_pc", bus.instr_pc, ei.pc);
        check("sb_instr", 64'(bus.instr), 64'(ei.instr));
      end
    end
    if (bus.mem_resp_valid) begin
      if (exp_req_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got response, expected none scheduled");
      end else begin
        er = exp_req_q.pop_front();
        check("sb_req_valid", 64'(bus.mem_req_valid), 64'(er.req_valid));
        check("sb_req_addr", bus.mem_req_addr, er.addr);
      end
    end
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.instr_ready    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_req_addr", bus.mem_req_addr, 64'd0);
    check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_instr_pc", bus.instr_pc, 64'd0);
    reset = 1'b1;
    tick();

    // Response in IDLE is ignored
    respond(32'h900, 1'b0, 64'd0);
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    check("idle_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("idle_req_valid", 64'(bus.mem_req_valid), 64'd0);

    // Entry redirect and first line
    redirect(64'h1000_0008);
    tick();
    bus.redirect_valid = 1'b0;
    check("entry_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("entry_req_addr", bus.mem_req_addr, 64'h1000_0000);
    tick();
    check("entry_req_hold", 64'(bus.mem_req_valid), 64'd1);
    respond(32'h100, 1'b1, 64'h1000_0000);
    tick();
    bus.mem_resp_valid = 1'b0;
    check("first_instr_valid", 64'(bus.instr_valid), 64'd1);
    check("first_instr", 64'(bus.instr), 64'h102);
    check("first_instr_pc", bus.instr_pc, 64'h1000_0008);
    check("first_req_low", 64'(bus.mem_req_valid), 64'd0);

    // Stall: output held stable
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", 64'(bus.instr), 64'h102);
      check("stall_instr_pc", bus.instr_pc, 64'h1000_0008);
    end

    // Redirect hit in held line
    redirect(64'h1000_0020);
    tick();
    bus.redirect_valid = 1'b0;
    check("hit_instr_valid", 64'(bus.instr_valid), 64'd1);
    check("hit_instr", 64'(bus.instr), 64'h108);
    check("hit_instr_pc", bus.instr_pc, 64'h1000_0020);
    check("hit_no_req", 64'(bus.mem_req_valid), 64'd0);

    // Redirect beats handshake; 0x1000_0024 must never be accepted
    redirect(64'h1000_0031);
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    check("prio_instr_pc", bus.instr_pc, 64'h1000_0030);
    check("prio_instr", 64'(bus.instr), 64'h10C);

    // Stream to end of line, then line crossing
    redirect(64'h1000_0038);
    tick();
    bus.redirect_valid = 1'b0;
    expect_instr(64'h1000_0038, 32'h10E);
    expect_instr(64'h1000_003C, 32'h10F);
    bus.instr_ready = 1'b1;
    tick();
    tick();
    check("cross_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("cross_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("cross_req_addr", bus.mem_req_addr, 64'h1000_0040);

    // Redirect during REQ: first response dropped, request reissued
    redirect(64'h2000_0000);
    tick();
    bus.redirect_valid = 1'b0;
    check("disc_req_addr", bus.mem_req_addr, 64'h2000_0000);
    check("disc_instr_valid0", 64'(bus.instr_valid), 64'd0);
    respond(32'h200, 1'b1, 64'h2000_0000);
    tick();
    bus.mem_resp_valid = 1'b0;
    check("disc_instr_valid1", 64'(bus.instr_valid), 64'd0);
    check("disc_reissue_valid", 64'(bus.mem_req_valid), 64'd1);
    check("disc_reissue_addr", bus.mem_req_addr, 64'h2000_0000);
    respond(32'h300, 1'b1, 64'h2000_0000);
    expect_instr(64'h2000_0000, 32'h300);
    expect_instr(64'h2000_0004, 32'h301);
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    tick();
    bus.instr_ready = 1'b0;
    check("after_disc_pc", bus.instr_pc, 64'h2000_0008);
    check("after_disc_instr", 64'(bus.instr), 64'h302);

    // PC wrap at top of address space
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    bus.redirect_valid = 1'b0;
    check("wrap_req_addr", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFC0);
    respond(32'h400, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0);
    expect_instr(64'hFFFF_FFFF_FFFF_FFFC, 32'h40F);
    bus.instr_ready = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    bus.instr_ready = 1'b0;
    check("wrap_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("wrap_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("wrap_req_addr0", bus.mem_req_addr, 64'd0);

    // Reset mid-request, then a late response in IDLE
    #1 reset = 1'b0;
    #1;
    check("mid_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("mid_rst_req_addr", bus.mem_req_addr, 64'd0);
    check("mid_rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    respond(32'h500, 1'b0, 64'd0);
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    check("late_resp_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("late_resp_req_valid", 64'(bus.mem_req_valid), 64'd0);

    tick();
    check("instr_queue_drained", 64'(exp_instr_q.size()), 64'd0);
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
